// File: rtl/mypc_pkg.sv
// Shared types for the my_computer_nbit core: opcode encoding and control FSM states.
package mypc_pkg;

   localparam int unsigned OPC_W = 4;

   // One value per 4-bit opcode; the encoding is the instruction set itself.
   typedef enum logic [OPC_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_XCHG = 4'd2,
      OP_RCL  = 4'd3,
      OP_SHR  = 4'd4,
      OP_MOV  = 4'd5,
      OP_XOR  = 4'd6,
      OP_AND  = 4'd7,
      OP_OR   = 4'd8,
      OP_OUT  = 4'd9,
      OP_JZ   = 4'd10,
      OP_PUSH = 4'd11,
      OP_POP  = 4'd12,
      OP_CALL = 4'd13,
      OP_RET  = 4'd14,
      OP_HLT  = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

endpackage

// File: rtl/mypc_stack.sv
// Downward-growing LIFO stack with its stack pointer.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, pop_i    one-cycle operation requests (mutually exclusive)
//   wdata_i          word written by a push
//   pop_word_c_o     word a pop would return this cycle (combinational)
//   ok_c_o           requested operation is accepted (combinational)
//   sp_o             stack pointer, SD-1 when empty
//   err_o            sticky overflow/underflow flag
// Build option: MYPC_STACK_GUARD_EN suppresses overflow/underflow and raises err_o;
// without it the pointer wraps modulo SD and err_o is tied low.
module mypc_stack #(
   parameter int unsigned DW = 8,
   parameter int unsigned SD = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DW-1:0]         wdata_i,
   output logic [DW-1:0]         pop_word_c_o,
   output logic                  ok_c_o,
   output logic [$clog2(SD)-1:0] sp_o,
   output logic                  err_o
);

   localparam int unsigned SW = $clog2(SD);
   localparam logic [SW-1:0] SP_TOP = SW'(SD - 1);

   logic [DW-1:0] mem_q [SD];
   logic [SW-1:0] sp_q, sp_d;
   logic [SW-1:0] pop_idx;

`ifdef MYPC_STACK_GUARD_EN
   // full_q marks the SD-th entry used: SP then rests at 0 instead of wrapping.
   logic full_q, full_d;
   logic err_q, err_d;
   logic empty_c;

   assign empty_c = (sp_q == SP_TOP) && !full_q;
   assign ok_c_o  = push_i ? !full_q : (pop_i ? !empty_c : 1'b1);
   assign pop_idx = full_q ? sp_q : sp_q + SW'(1);
   assign err_o   = err_q;

   // Pointer, full and error next-state.
   always_comb begin
      sp_d   = sp_q;
      full_d = full_q;
      err_d  = err_q;
      if (push_i) begin
         if (full_q)            err_d  = 1'b1;
         else if (sp_q == '0)   full_d = 1'b1;
         else                   sp_d   = sp_q - SW'(1);
      end else if (pop_i) begin
         if (empty_c)           err_d  = 1'b1;
         else if (full_q)       full_d = 1'b0;
         else                   sp_d   = sp_q + SW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sp_q   <= SP_TOP;
         full_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         sp_q   <= sp_d;
         full_q <= full_d;
         err_q  <= err_d;
      end
   end
`else
   assign ok_c_o  = 1'b1;
   assign pop_idx = sp_q + SW'(1);
   assign err_o   = 1'b0;

   // Pointer next-state; wraps silently modulo SD.
   always_comb begin
      sp_d = sp_q;
      if (push_i)     sp_d = sp_q - SW'(1);
      else if (pop_i) sp_d = sp_q + SW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) sp_q <= SP_TOP;
      else       sp_q <= sp_d;
   end
`endif

   // Storage has no reset; contents are don't-care after reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push_i && ok_c_o) mem_q[sp_q] <= wdata_i;
   end

   assign pop_word_c_o = mem_q[pop_idx];
   assign sp_o         = sp_q;

endmodule

// File: rtl/my_computer_nbit.sv
// Tiny accumulator-style computer: fetches one externally supplied instruction,
// executes it the next cycle, and exposes its architectural registers.
// Ports:
//   mypc_clock, mypc_reset      clock, synchronous active-high reset
//   A, B                        data operands (DW)
//   pc_instr, instr_addr        opcode and memory/jump operand (AW)
//   instr_valid / instr_ready   instruction handshake; ready only while fetching
//   mypc_outA, mypc_outB        result registers
//   stack_output                last pushed word, 0 after a pop
//   IP, SP                      instruction and stack pointers
//   zf, cf                      zero and carry flags
//   stop_flag                   core halted until reset
//   stack_err                   sticky stack guard error
// Build option: MYPC_STACK_GUARD_EN (handled in mypc_stack) enables stack guarding.
module my_computer_nbit
   import mypc_pkg::*;
#(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 4,
   parameter int unsigned SD = 16
) (
   input  logic                  mypc_clock,
   input  logic                  mypc_reset,
   input  logic [DW-1:0]         A,
   input  logic [DW-1:0]         B,
   input  logic [3:0]            pc_instr,
   input  logic [AW-1:0]         instr_addr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   output logic [DW-1:0]         mypc_outA,
   output logic [DW-1:0]         mypc_outB,
   output logic [DW-1:0]         stack_output,
   output logic [AW-1:0]         IP,
   output logic [$clog2(SD)-1:0] SP,
   output logic                  zf,
   output logic                  cf,
   output logic                  stop_flag,
   output logic                  stack_err
);

   state_e        state_q, state_d;
   opcode_e       op_q, op_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic [DW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic [DW-1:0] stk_out_q, stk_out_d;
   logic [AW-1:0] ip_q, ip_d;
   logic          zf_q, zf_d, cf_q, cf_d;

   logic [AW-1:0] ip_inc;
   logic [DW:0]   sum_w, diff_w;
   logic [DW-1:0] ram_word;
   logic          exec_c;

   logic          stk_push, stk_pop, stk_ok;
   logic [DW-1:0] stk_wdata, stk_pop_word;

   // Read-only RAM holding RAM[k] = k mod 2**DW, so a lookup is just the address.
   assign ram_word = DW'(addr_q);

   assign ip_inc = ip_q + AW'(1);
   assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
   assign diff_w = {1'b0, a_q} - {1'b0, b_q};

   assign exec_c    = (state_q == ST_EXEC);
   assign stk_push  = exec_c && ((op_q == OP_PUSH) || (op_q == OP_CALL));
   assign stk_pop   = exec_c && ((op_q == OP_POP)  || (op_q == OP_RET));
   // CALL saves the return address, zero-extended to a stack word.
   assign stk_wdata = (op_q == OP_CALL) ? DW'(ip_inc) : b_q;

   mypc_stack #(
      .DW (DW),
      .SD (SD)
   ) u_stack (
      .clk_i        (mypc_clock),
      .rst_i        (mypc_reset),
      .push_i       (stk_push),
      .pop_i        (stk_pop),
      .wdata_i      (stk_wdata),
      .pop_word_c_o (stk_pop_word),
      .ok_c_o       (stk_ok),
      .sp_o         (SP),
      .err_o        (stack_err)
   );

   // Next-state and execute datapath.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      a_d       = a_q;
      b_d       = b_q;
      out_a_d   = out_a_q;
      out_b_d   = out_b_q;
      stk_out_d = stk_out_q;
      ip_d      = ip_q;
      zf_d      = zf_q;
      cf_d      = cf_q;

      case (state_q)
         ST_FETCH: begin
            if (instr_valid) begin
               op_d    = opcode_e'(pc_instr);
               addr_d  = instr_addr;
               a_d     = A;
               b_d     = B;
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d = ST_FETCH;
            ip_d    = ip_inc;
            case (op_q)
               OP_ADD: begin
                  out_a_d = sum_w[DW-1:0];
                  cf_d    = sum_w[DW];
                  zf_d    = (sum_w[DW-1:0] == '0);
               end
               OP_SUB: begin
                  out_a_d = diff_w[DW-1:0];
                  cf_d    = diff_w[DW];
                  zf_d    = (diff_w[DW-1:0] == '0);
               end
               OP_XCHG: begin
                  out_a_d = b_q;
                  out_b_d = a_q;
               end
               OP_RCL: begin
                  // Rotate B left through carry: old cf enters bit 0.
                  out_b_d = {b_q[DW-2:0], cf_q};
                  cf_d    = b_q[DW-1];
                  zf_d    = ({b_q[DW-2:0], cf_q} == '0);
               end
               OP_SHR: begin
                  out_a_d = {1'b0, a_q[DW-1:1]};
                  cf_d    = a_q[0];
               end
               OP_MOV: begin
                  out_a_d = ram_word;
                  zf_d    = (ram_word == '0);
               end
               OP_XOR: begin
                  out_a_d = a_q ^ ram_word;
                  zf_d    = ((a_q ^ ram_word) == '0);
               end
               OP_AND: begin
                  out_a_d = a_q & b_q;
                  zf_d    = ((a_q & b_q) == '0);
               end
               OP_OR: begin
                  out_b_d = b_q | ram_word;
                  zf_d    = ((b_q | ram_word) == '0);
               end
               OP_OUT: begin
                  out_a_d = a_q;
                  zf_d    = (a_q == '0);
               end
               OP_JZ: begin
                  if (zf_q) ip_d = addr_q;
               end
               OP_PUSH: begin
                  if (stk_ok) stk_out_d = b_q;
               end
               OP_POP: begin
                  if (stk_ok) begin
                     out_b_d   = stk_pop_word;
                     zf_d      = (stk_pop_word == '0);
                     stk_out_d = '0;
                  end
               end
               OP_CALL: begin
                  if (stk_ok) begin
                     ip_d      = addr_q;
                     stk_out_d = stk_wdata;
                  end
               end
               OP_RET: begin
                  if (stk_ok) begin
                     ip_d      = AW'(stk_pop_word);
                     stk_out_d = '0;
                  end
               end
               OP_HLT: begin
                  ip_d    = ip_q;
                  state_d = ST_HALT;
               end
            endcase
         end

         ST_HALT: begin
         end

         default: state_d = ST_FETCH;
      endcase
   end

   // State registers; reset aborts any instruction in flight.
   always_ff @(posedge mypc_clock) begin
      if (mypc_reset) begin
         state_q   <= ST_FETCH;
         op_q      <= OP_ADD;
         addr_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         out_a_q   <= '0;
         out_b_q   <= '0;
         stk_out_q <= '0;
         ip_q      <= '0;
         zf_q      <= 1'b0;
         cf_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         out_a_q   <= out_a_d;
         out_b_q   <= out_b_d;
         stk_out_q <= stk_out_d;
         ip_q      <= ip_d;
         zf_q      <= zf_d;
         cf_q      <= cf_d;
      end
   end

   assign instr_ready  = (state_q == ST_FETCH);
   assign stop_flag    = (state_q == ST_HALT);
   assign mypc_outA    = out_a_q;
   assign mypc_outB    = out_b_q;
   assign stack_output = stk_out_q;
   assign IP           = ip_q;
   assign zf           = zf_q;
   assign cf           = cf_q;

endmodule

// File: tb/tb_my_computer_nbit.sv
// Scoreboard bench for my_computer_nbit with an architectural reference model.
module tb_my_computer_nbit;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned SD = 16;
   localparam int unsigned SW = 4;

   logic          mypc_clock;
   logic          mypc_reset;
   logic [DW-1:0] A, B;
   logic [3:0]    pc_instr;
   logic [AW-1:0] instr_addr;
   logic          instr_valid, instr_ready;
   logic [DW-1:0] mypc_outA, mypc_outB, stack_output;
   logic [AW-1:0] IP;
   logic [SW-1:0] SP;
   logic          zf, cf, stop_flag, stack_err;

   my_computer_nbit #(.DW(DW), .AW(AW), .SD(SD)) dut (
      .mypc_clock   (mypc_clock),
      .mypc_reset   (mypc_reset),
      .A            (A),
      .B            (B),
      .pc_instr     (pc_instr),
      .instr_addr   (instr_addr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .mypc_outA    (mypc_outA),
      .mypc_outB    (mypc_outB),
      .stack_output (stack_output),
      .IP           (IP),
      .SP           (SP),
      .zf           (zf),
      .cf           (cf),
      .stop_flag    (stop_flag),
      .stack_err    (stack_err)
   );

   initial mypc_clock = 1'b0;
   always #5 mypc_clock = ~mypc_clock;

   typedef struct {
      string         tag;
      logic [DW-1:0] outa, outb, stko;
      logic [AW-1:0] ip;
      logic [SW-1:0] sp;
      logic          zf, cf, err;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec;
   int   n_miscmp;

   // Reference model state
   logic [DW-1:0] m_outa, m_outb, m_stko;
   logic [AW-1:0] m_ip;
   logic [SW-1:0] m_sp;
   int            m_cnt;
   logic          m_zf, m_cf, m_err;
   logic [DW-1:0] m_mem [SD];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_outa = '0; m_outb = '0; m_stko = '0; m_ip = '0;
      m_sp = SW'(SD - 1); m_cnt = 0;
      m_zf = 1'b0; m_cf = 1'b0; m_err = 1'b0;
   endtask

   function automatic logic [SW-1:0] model_sp();
`ifdef MYPC_STACK_GUARD_EN
      return (m_cnt == SD) ? '0 : SW'(SD - 1 - m_cnt);
`else
      return m_sp;
`endif
   endfunction

   task automatic m_push(input logic [DW-1:0] w, output bit ok);
`ifdef MYPC_STACK_GUARD_EN
      if (m_cnt == SD) begin ok = 0; m_err = 1'b1; end
      else begin m_mem[SD - 1 - m_cnt] = w; m_cnt++; ok = 1; end
`else
      m_mem[m_sp] = w; m_sp = m_sp - 1'b1; ok = 1;
`endif
   endtask

   task automatic m_pop(output logic [DW-1:0] w, output bit ok);
`ifdef MYPC_STACK_GUARD_EN
      if (m_cnt == 0) begin ok = 0; m_err = 1'b1; w = '0; end
      else begin m_cnt--; w = m_mem[SD - 1 - m_cnt]; ok = 1; end
`else
      m_sp = m_sp + 1'b1; w = m_mem[m_sp]; ok = 1;
`endif
   endtask

   task automatic model_step(input logic [3:0] op, input logic [AW-1:0] addr,
                             input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
      logic [DW:0]   t;
      logic [DW-1:0] w, ram;
      logic [AW-1:0] nip;
      bit            ok;
      exp_t          e;
      ram = DW'(addr);
      nip = m_ip + 1'b1;
      case (op)
         4'd0:  begin t = {1'b0, a} + {1'b0, b}; m_outa = t[DW-1:0]; m_cf = t[DW]; m_zf = (m_outa == 0); end
         4'd1:  begin t = {1'b0, a} - {1'b0, b}; m_outa = t[DW-1:0]; m_cf = t[DW]; m_zf = (m_outa == 0); end
         4'd2:  begin m_outa = b; m_outb = a; end
         4'd3:  begin m_outb = {b[DW-2:0], m_cf}; m_cf = b[DW-1]; m_zf = (m_outb == 0); end
         4'd4:  begin m_outa = a >> 1; m_cf = a[0]; end
         4'd5:  begin m_outa = ram; m_zf = (m_outa == 0); end
         4'd6:  begin m_outa = a ^ ram; m_zf = (m_outa == 0); end
         4'd7:  begin m_outa = a & b; m_zf = (m_outa == 0); end
         4'd8:  begin m_outb = b | ram; m_zf = (m_outb == 0); end
         4'd9:  begin m_outa = a; m_zf = (m_outa == 0); end
         4'd10: begin if (m_zf) nip = addr; end
         4'd11: begin m_push(b, ok); if (ok) m_stko = b; end
         4'd12: begin m_pop(w, ok); if (ok) begin m_outb = w; m_zf = (w == 0); m_stko = '0; end end
         4'd13: begin
            w = DW'(nip);
            m_push(w, ok);
            if (ok) begin nip = addr; m_stko = w; end
         end
         4'd14: begin m_pop(w, ok); if (ok) begin nip = AW'(w); m_stko = '0; end end
         default: nip = m_ip;
      endcase
      m_ip = nip;
      e.tag = tag; e.outa = m_outa; e.outb = m_outb; e.stko = m_stko;
      e.ip = m_ip; e.sp = model_sp(); e.zf = m_zf; e.cf = m_cf; e.err = m_err;
      sb_q.push_back(e);
   endtask

   task automatic compare_next();
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("sb_underrun", 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      check_eq({e.tag, ".outA"}, 32'(mypc_outA), 32'(e.outa));
      check_eq({e.tag, ".outB"}, 32'(mypc_outB), 32'(e.outb));
      check_eq({e.tag, ".stk"},  32'(stack_output), 32'(e.stko));
      check_eq({e.tag, ".IP"},   32'(IP), 32'(e.ip));
      check_eq({e.tag, ".SP"},   32'(SP), 32'(e.sp));
      check_eq({e.tag, ".zf"},   32'(zf), 32'(e.zf));
      check_eq({e.tag, ".cf"},   32'(cf), 32'(e.cf));
      check_eq({e.tag, ".err"},  32'(stack_err), 32'(e.err));
   endtask

   // Called at posedge+1; offers one instruction and checks it after execution.
   task automatic issue(input logic [3:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(posedge mypc_clock); #1;
         n++;
      end
      if (!instr_ready) begin
         check_eq({tag, ".ready_timeout"}, 32'(instr_ready), 32'd1);
         return;
      end
      pc_instr = op; instr_addr = addr; A = a; B = b; instr_valid = 1'b1;
      model_step(op, addr, a, b, tag);
      @(posedge mypc_clock); #1;
      instr_valid = 1'b0;
      check_eq({tag, ".ready_exec"}, 32'(instr_ready), 32'd0);
      @(posedge mypc_clock); #1;
      compare_next();
   endtask

   task automatic do_reset();
      mypc_reset = 1'b1;
      @(posedge mypc_clock); @(posedge mypc_clock); #1;
      mypc_reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_miscmp = 0;
      A = '0; B = '0; pc_instr = '0; instr_addr = '0; instr_valid = 1'b0;
      mypc_reset = 1'b0;
      @(posedge mypc_clock); #1;
      do_reset();

      // Reset values
      check_eq("rst.outA", 32'(mypc_outA), 32'd0);
      check_eq("rst.outB", 32'(mypc_outB), 32'd0);
      check_eq("rst.stk", 32'(stack_output), 32'd0);
      check_eq("rst.IP", 32'(IP), 32'd0);
      check_eq("rst.SP", 32'(SP), 32'(SD - 1));
      check_eq("rst.zf", 32'(zf), 32'd0);
      check_eq("rst.cf", 32'(cf), 32'd0);
      check_eq("rst.stop", 32'(stop_flag), 32'd0);
      check_eq("rst.err", 32'(stack_err), 32'd0);
      check_eq("rst.ready", 32'(instr_ready), 32'd1);

      // Carry out of ADD, then RCL and SUB borrow
      issue(4'd0, 4'd0, 8'hF0, 8'h10, "add_f0_10");
      check_eq("add.outA", 32'(mypc_outA), 32'h00);
      check_eq("add.zf", 32'(zf), 32'd1);
      check_eq("add.cf", 32'(cf), 32'd1);
      issue(4'd3, 4'd0, 8'h00, 8'h80, "rcl_80");
      check_eq("rcl.outB", 32'(mypc_outB), 32'h01);
      check_eq("rcl.cf", 32'(cf), 32'd1);
      issue(4'd1, 4'd0, 8'h03, 8'h05, "sub_3_5");
      check_eq("sub.outA", 32'(mypc_outA), 32'hFE);
      check_eq("sub.cf", 32'(cf), 32'd1);
      check_eq("sub.zf", 32'(zf), 32'd0);

      // Remaining ALU/RAM ops and both JZ outcomes
      issue(4'd2,  4'd0, 8'h12, 8'h34, "xchg");
      issue(4'd4,  4'd0, 8'h03, 8'h00, "shr");
      issue(4'd5,  4'd7, 8'h00, 8'h00, "mov7");
      issue(4'd6,  4'd5, 8'h0F, 8'h00, "xor5");
      issue(4'd7,  4'd0, 8'hF0, 8'h0F, "and_zero");
      issue(4'd8,  4'd3, 8'h00, 8'h40, "or3");
      issue(4'd9,  4'd0, 8'h55, 8'h00, "out55");
      issue(4'd10, 4'd12, 8'h00, 8'h00, "jz_not_taken");
      issue(4'd9,  4'd0, 8'h00, 8'h00, "out0");
      issue(4'd10, 4'd12, 8'h00, 8'h00, "jz_taken");
      check_eq("jz.IP", 32'(IP), 32'd12);
      issue(4'd5,  4'd0, 8'h00, 8'h00, "mov0");

      // Random ALU/JZ traffic
      for (int i = 0; i < 24; i++) begin
         issue(4'($urandom_range(0, 10)), 4'($urandom_range(0, 15)),
               8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
      end

      // CALL/RET
      do_reset();
      issue(4'd9, 4'd0, 8'h01, 8'h00, "pre0");
      issue(4'd9, 4'd0, 8'h02, 8'h00, "pre1");
      issue(4'd13, 4'd9, 8'h00, 8'h00, "call9");
      check_eq("call.IP", 32'(IP), 32'd9);
      check_eq("call.SP", 32'(SP), 32'(SD - 2));
      issue(4'd14, 4'd0, 8'h00, 8'h00, "ret");
      check_eq("ret.IP", 32'(IP), 32'd3);
      check_eq("ret.SP", 32'(SP), 32'(SD - 1));

      // PUSH/POP ordering
      issue(4'd11, 4'd0, 8'h00, 8'hA5, "push_a5");
      issue(4'd11, 4'd0, 8'h00, 8'h3C, "push_3c");
      check_eq("push.stk", 32'(stack_output), 32'h3C);
      issue(4'd12, 4'd0, 8'h00, 8'h00, "pop1");
      check_eq("pop1.outB", 32'(mypc_outB), 32'h3C);
      check_eq("pop1.stk", 32'(stack_output), 32'h00);
      issue(4'd12, 4'd0, 8'h00, 8'h00, "pop2");
      check_eq("pop2.outB", 32'(mypc_outB), 32'hA5);

      // Overflow: SD pushes fill the stack, one more overflows
      do_reset();
      for (int i = 0; i < SD; i++) issue(4'd11, 4'd0, 8'h00, 8'(i + 1), $sformatf("fill%0d", i));
`ifdef MYPC_STACK_GUARD_EN
      check_eq("full.SP", 32'(SP), 32'd0);
      issue(4'd11, 4'd0, 8'h00, 8'hEE, "overflow");
      check_eq("ovf.SP", 32'(SP), 32'd0);
      check_eq("ovf.err", 32'(stack_err), 32'd1);
`else
      check_eq("wrap.SP", 32'(SP), 32'(SD - 1));
      issue(4'd11, 4'd0, 8'h00, 8'hEE, "overflow");
      check_eq("wrap2.SP", 32'(SP), 32'(SD - 2));
      check_eq("wrap.err", 32'(stack_err), 32'd0);
`endif
      issue(4'd12, 4'd0, 8'h00, 8'h00, "pop_after_full");

      // Underflow from an empty stack
      do_reset();
      issue(4'd12, 4'd0, 8'h00, 8'h00, "pop_empty");
      issue(4'd14, 4'd0, 8'h00, 8'h00, "ret_empty");

      // HLT freezes the core even with a valid instruction on offer
      do_reset();
      issue(4'd9, 4'd0, 8'h77, 8'h00, "pre_hlt");
      issue(4'd15, 4'd0, 8'h00, 8'h00, "hlt");
      pc_instr = 4'd0; A = 8'h01; B = 8'h01; instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge mypc_clock); #1;
         check_eq($sformatf("halt%0d.stop", i), 32'(stop_flag), 32'd1);
         check_eq($sformatf("halt%0d.ready", i), 32'(instr_ready), 32'd0);
         check_eq($sformatf("halt%0d.IP", i), 32'(IP), 32'(m_ip));
         check_eq($sformatf("halt%0d.outA", i), 32'(mypc_outA), 32'h77);
      end
      instr_valid = 1'b0;

      // Reset landing on the EXEC cycle of an ADD discards its results
      do_reset();
      pc_instr = 4'd0; A = 8'hF0; B = 8'h10; instr_addr = '0; instr_valid = 1'b1;
      @(posedge mypc_clock); #1;
      instr_valid = 1'b0;
      mypc_reset = 1'b1;
      @(posedge mypc_clock); #1;
      mypc_reset = 1'b0;
      model_reset();
      check_eq("rstexec.outA", 32'(mypc_outA), 32'd0);
      check_eq("rstexec.zf", 32'(zf), 32'd0);
      check_eq("rstexec.cf", 32'(cf), 32'd0);
      check_eq("rstexec.IP", 32'(IP), 32'd0);
      check_eq("rstexec.ready", 32'(instr_ready), 32'd1);
      check_eq("rstexec.stop", 32'(stop_flag), 32'd0);
      issue(4'd0, 4'd0, 8'h01, 8'h02, "add_after_rst");

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
